ks_cmd_sequencer: RTL and testbench

Sequences one key-switch operation for the HPU key-switch datapath. Each accepted request carries one big-LWE ciphertext ID (PID). The block walks all GLWE_K·N mask coefficients and KS_L decomposition levels, emitting one (coefficient, level) command per cycle toward the KSK fetch/MAC pipeline, then emits a single body command. A credit counter mirrors the downstream KSK slot buffer: no command needing a KSK word is issued without a free slot.

---
 rtl/ks_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ks_cmd_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_cmd_sequencer.sv
// Key-switch command sequencer: walks LWE_IN x KS_L mask commands plus one body
// command per request, gated by a credit counter mirroring the KSK slot buffer.
module ks_cmd_sequencer #(
  parameter int LWE_IN     = 2048,
  parameter int KS_L       = 8,
  parameter int CREDIT_MAX = 16,
  parameter int PID_W      = 6,
  localparam int COEF_W    = $clog2(LWE_IN),
  localparam int LVL_W     = $clog2(KS_L)
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              start_vld,
  output logic              start_rdy,
  input  logic [PID_W-1:0]  start_pid,
  output logic              cmd_vld,
  input  logic              cmd_rdy,
  output logic [COEF_W-1:0] cmd_coef,
  output logic [LVL_W-1:0]  cmd_lvl,
  output logic              cmd_body,
  output logic              cmd_last,
  output logic [PID_W-1:0]  cmd_pid,
  input  logic              credit_inc,
  output logic              done_vld,
  output logic [PID_W-1:0]  done_pid,
  output logic              busy,
  output logic              err_credit_ovf
);

  // state | meaning
  // IDLE  | waiting for a request, start_rdy high
  // RUN   | issuing mask commands, one per available credit
  // BODY  | issuing the single body command, needs no credit
  // DONE  | one-cycle completion pulse, then back to IDLE

  localparam int CRD_W = $clog2(CREDIT_MAX + 1);
  localparam logic [COEF_W-1:0] COEF_MAX = COEF_W'(LWE_IN - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(KS_L - 1);
  localparam logic [CRD_W-1:0]  CRD_FULL = CRD_W'(CREDIT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BODY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COEF_W-1:0]  r_coef;
  logic [LVL_W-1:0]   r_lvl;
  logic [PID_W-1:0]   r_pid;
  logic [CRD_W-1:0]   r_credit;
  logic               r_err;
  logic               r_body;
  logic               r_done;
  logic [PID_W-1:0]   r_done_pid;
  logic               r_busy;

  logic w_cmd_vld;
  logic w_hs;
  logic w_consume;
  logic w_last_mask;
  logic w_ld_start;

  assign w_cmd_vld   = ((r_state == ST_RUN) && (r_credit != '0)) || (r_state == ST_BODY);
  assign w_hs        = w_cmd_vld && cmd_rdy;
  assign w_consume   = w_hs && (r_state == ST_RUN);
  assign w_last_mask = (r_coef == COEF_MAX) && (r_lvl == LVL_MAX);

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_vld) begin
          w_state_nxt = ST_RUN;
          w_ld_start  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_consume && w_last_mask) begin
          w_state_nxt = ST_BODY;
        end
      end
      ST_BODY: begin
        if (w_hs) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Level is the fast index; both counters wrap to zero after the last mask
  // command, so coef/lvl already read zero while the body command is shown.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_coef <= '0;
      r_lvl  <= '0;
      r_pid  <= '0;
    end else if (w_ld_start) begin
      r_coef <= '0;
      r_lvl  <= '0;
      r_pid  <= start_pid;
    end else if (w_consume) begin
      if (r_lvl == LVL_MAX) begin
        r_lvl  <= '0;
        r_coef <= (r_coef == COEF_MAX) ? '0 : r_coef + COEF_W'(1);
      end else begin
        r_lvl <= r_lvl + LVL_W'(1);
      end
    end
  end

  // A return and a consume in the same cycle cancel, so a full counter with
  // a simultaneous consume is not an overflow.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_credit <= CRD_FULL;
      r_err    <= 1'b0;
    end else if (credit_inc && !w_consume) begin
      if (r_credit == CRD_FULL) begin
        r_err <= 1'b1;
      end else begin
        r_credit <= r_credit + CRD_W'(1);
      end
    end else if (!credit_inc && w_consume) begin
      r_credit <= r_credit - CRD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_body     <= 1'b0;
      r_done     <= 1'b0;
      r_done_pid <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_body <= (w_state_nxt == ST_BODY);
      r_done <= (w_state_nxt == ST_DONE);
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_state_nxt == ST_DONE) begin
        r_done_pid <= r_pid;
      end
    end
  end

  assign start_rdy      = (r_state == ST_IDLE);
  assign cmd_vld        = w_cmd_vld;
  assign cmd_coef       = r_coef;
  assign cmd_lvl        = r_lvl;
  assign cmd_body       = r_body;
  assign cmd_last       = r_body;
  assign cmd_pid        = r_pid;
  assign done_vld       = r_done;
  assign done_pid       = r_done_pid;
  assign busy           = r_busy;
  assign err_credit_ovf = r_err;

endmodule

// File: tb/tb_ks_cmd_sequencer.sv
// Scoreboard bench for ks_cmd_sequencer: a monitor compares every presented
// command and completion against queues filled from a cycle-level reference model.
module tb_ks_cmd_sequencer;

  localparam int LWE_IN     = 2048;
  localparam int KS_L       = 8;
  localparam int CREDIT_MAX = 16;
  localparam int PID_W      = 6;
  localparam int COEF_W     = 11;
  localparam int LVL_W      = 3;
  localparam int EB         = COEF_W + LVL_W;

  logic              clk;
  logic              s_rst_n;
  logic              start_vld;
  logic              start_rdy;
  logic [PID_W-1:0]  start_pid;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [COEF_W-1:0] cmd_coef;
  logic [LVL_W-1:0]  cmd_lvl;
  logic              cmd_body;
  logic              cmd_last;
  logic [PID_W-1:0]  cmd_pid;
  logic              credit_inc;
  logic              done_vld;
  logic [PID_W-1:0]  done_pid;
  logic              busy;
  logic              err_credit_ovf;

  ks_cmd_sequencer #(
    .LWE_IN(LWE_IN), .KS_L(KS_L), .CREDIT_MAX(CREDIT_MAX), .PID_W(PID_W)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .start_vld(start_vld), .start_rdy(start_rdy), .start_pid(start_pid),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_coef(cmd_coef), .cmd_lvl(cmd_lvl),
    .cmd_body(cmd_body), .cmd_last(cmd_last), .cmd_pid(cmd_pid),
    .credit_inc(credit_inc), .done_vld(done_vld), .done_pid(done_pid),
    .busy(busy), .err_credit_ovf(err_credit_ovf)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [EB:0]      exp_q[$];
  logic [PID_W-1:0] done_q[$];
  int  m_credit   = CREDIT_MAX;
  bit  m_err      = 0;
  bit  m_active   = 0;
  int  m_body_cyc = -10;

  initial begin : monitor
    logic [EB:0] e;
    bit e_vld, e_done, hs, cons, acc;
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        chk("reset_outputs",
            {start_rdy, cmd_vld, cmd_body, cmd_last, cmd_coef, cmd_lvl, cmd_pid,
             done_vld, done_pid, busy, err_credit_ovf},
            {1'b1, 32'd0});
        exp_q.delete();
        done_q.delete();
        m_credit   = CREDIT_MAX;
        m_err      = 0;
        m_active   = 0;
        m_body_cyc = -10;
      end else begin
        if (exp_q.size() == 0)  e_vld = 0;
        else if (exp_q[0][EB])  e_vld = 1;
        else                    e_vld = (m_credit != 0);
        e_done = m_active && (cyc == m_body_cyc + 1);
        chk("cmd_vld", cmd_vld, e_vld);
        chk("start_rdy", start_rdy, !m_active);
        chk("busy", busy, m_active);
        chk("err_credit_ovf", err_credit_ovf, m_err);
        chk("done_vld", done_vld, e_done);
        if (done_vld && done_q.size() > 0) chk("done_pid", done_pid, done_q[0]);
        if (cmd_vld && exp_q.size() > 0 && done_q.size() > 0) begin
          e = exp_q[0];
          chk("cmd_fields", {cmd_last, cmd_body, cmd_coef, cmd_lvl, cmd_pid},
              {e[EB], e, done_q[0]});
        end
        hs   = cmd_vld && cmd_rdy;
        cons = hs && (exp_q.size() > 0) && !exp_q[0][EB];
        acc  = start_vld && !m_active;
        if (hs && exp_q.size() > 0) begin
          if (exp_q[0][EB]) m_body_cyc = cyc;
          void'(exp_q.pop_front());
        end
        if (e_done) begin
          m_active   = 0;
          m_body_cyc = -10;
          if (done_q.size() > 0) void'(done_q.pop_front());
        end
        if (credit_inc && !cons) begin
          if (m_credit == CREDIT_MAX) m_err = 1;
          else m_credit++;
        end else if (!credit_inc && cons) begin
          m_credit--;
        end
        if (acc) begin
          m_active = 1;
          done_q.push_back(start_pid);
          for (int c = 0; c < LWE_IN; c++)
            for (int l = 0; l < KS_L; l++)
              exp_q.push_back({1'b0, COEF_W'(c), LVL_W'(l)});
          exp_q.push_back({1'b1, {EB{1'b0}}});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit  loop_en  = 0;
  int  rdy_mode = 0;   // 0 low, 1 high, 2 random
  int  hs_cnt   = 0;
  int  done_cnt = 0;
  int  acc_cnt  = 0;
  int  last_done_cyc = 0;
  int  last_acc_cyc  = 0;
  bit  s_vld, s_err, s_busy, s_done, s_srdy;

  task automatic step(input bit inc_man);
    bit mask_hs;
    @(negedge clk);
    mask_hs = cmd_vld && cmd_rdy && !cmd_body;
    s_vld = cmd_vld; s_err = err_credit_ovf; s_busy = busy;
    s_done = done_vld; s_srdy = start_rdy;
    if (cmd_vld && cmd_rdy) hs_cnt++;
    if (done_vld) begin done_cnt++; last_done_cyc = cyc; end
    if (start_vld && start_rdy) begin acc_cnt++; last_acc_cyc = cyc; end
    @(posedge clk);
    #1;
    credit_inc = (loop_en && mask_hs) || inc_man;
    cmd_rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  endtask

  task automatic start_op(input logic [PID_W-1:0] pid);
    int a0;
    a0 = acc_cnt;
    start_pid = pid;
    start_vld = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) step(1'b0);
    chk("start_accept", acc_cnt, a0 + 1);
    start_vld = 1'b0;
  endtask

  initial begin : stim
    int base, d0;
    s_rst_n = 1'b1; start_vld = 1'b0; start_pid = '0; cmd_rdy = 1'b0; credit_inc = 1'b0;
    #1 s_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 s_rst_n = 1'b1;
    repeat (2) step(1'b0);

    // nominal run with start_vld held; a second request waits behind it
    loop_en = 1; rdy_mode = 1;
    start_pid = 6'h2A; start_vld = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == 0; i++) step(1'b0);
    chk("op1_accept", acc_cnt, 1);
    start_pid = PID_W'($urandom_range(0, 63));
    for (int i = 0; i < 20000 && acc_cnt < 2; i++) step(1'b0);
    chk("op1_done_count", done_cnt, 1);
    chk("start2_after_done", last_acc_cyc, last_done_cyc + 1);
    start_vld = 1'b0;

    // backpressure run on the second request
    rdy_mode = 2;
    step(1'b0);
    chk("vld_after_start", s_vld, 1);
    for (int i = 0; i < 45000 && done_cnt < 2; i++) step(1'b0);
    chk("op2_done_count", done_cnt, 2);
    repeat (4) step(1'b0);

    // credit starvation
    loop_en = 0; rdy_mode = 1;
    start_op(PID_W'($urandom_range(0, 63)));
    base = hs_cnt;
    repeat (40) step(1'b0);
    chk("starve_16", hs_cnt - base, 16);
    repeat (3) step(1'b1);
    repeat (20) step(1'b0);
    chk("starve_plus3", hs_cnt - base, 19);

    // return + consume together at five credits
    rdy_mode = 0;
    repeat (5) step(1'b1);
    base = hs_cnt;
    rdy_mode = 1;
    step(1'b1);
    repeat (25) step(1'b0);
    chk("credit5_simul", hs_cnt - base, 6);

    // overflow: fill to CREDIT_MAX then one more return
    rdy_mode = 0;
    repeat (16) step(1'b1);
    step(1'b0);
    chk("no_ovf_at_full", s_err, 0);
    step(1'b1);
    repeat (2) step(1'b0);
    chk("ovf_set", s_err, 1);

    // run to command 1000 then reset mid-operation
    base = hs_cnt - 25;
    loop_en = 1; rdy_mode = 1;
    for (int i = 0; i < 3000 && (hs_cnt - base) < 1000; i++) step(1'b0);
    chk("cmd_1000_reached", hs_cnt - base, 1000);
    chk("ovf_sticky", s_err, 1);
    d0 = done_cnt;
    loop_en = 0;
    s_rst_n = 1'b0;
    repeat (3) step(1'b0);
    chk("rst_mid_state", {s_srdy, s_vld, s_busy, s_err, s_done}, 5'b10000);
    s_rst_n = 1'b1;
    repeat (3) step(1'b0);
    chk("no_done_after_rst", done_cnt, d0);

    // fresh start after reset: full credits, restarts at (0,0)
    start_op(PID_W'($urandom_range(0, 63)));
    base = hs_cnt;
    repeat (40) step(1'b0);
    chk("post_rst_credits", hs_cnt - base, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
